// File: rtl/uxn_pkg.sv
// rtl/uxn_pkg.sv - shared types and constants for the Uxn multicycle sequencer
package uxn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_POP,
        ST_EXEC,
        ST_MEM,
        ST_PUSH,
        ST_FAULT
    } seq_state_t;

    typedef enum logic [1:0] {
        MEM_NONE = 2'd0,
        MEM_LD   = 2'd1,
        MEM_ST   = 2'd2,
        MEM_RSV  = 2'd3
    } mem_op_t;

    localparam int IR_SHORT_BIT = 5;
    localparam int IR_RET_BIT   = 6;
    localparam int IR_KEEP_BIT  = 7;

    // Wide enough for the largest decoder count (7) doubled in short mode.
    localparam int XFER_W = 4;

    function automatic logic [XFER_W-1:0] xfer_bytes(input logic [2:0] n, input logic short_mode);
        return short_mode ? {n, 1'b0} : {1'b0, n};
    endfunction

endpackage

// File: rtl/uxn_mc_sequencer_if.sv
// rtl/uxn_mc_sequencer_if.sv - memory, decoder, stack and ALU strobes around the sequencer
interface uxn_mc_sequencer_if;
    import uxn_pkg::*;

    logic       mem_req;
    logic       mem_we;
    logic       mem_ack;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic [2:0] dec_pop_n;
    logic [2:0] dec_push_n;
    mem_op_t    dec_mem;
    logic       dec_jump;
    logic       dec_brk;
    logic       ir_short;
    logic       ir_ret;
    logic       ir_keep;
    logic       alu_take;
    logic       stk_pop;
    logic       stk_push;
    logic       stk_sel;
    logic       stk_keep;
    logic       stk_err;
    logic       alu_en;

    modport master (
        output mem_req, mem_we, ir_load, pc_inc, pc_load,
               stk_pop, stk_push, stk_sel, stk_keep, alu_en,
        input  mem_ack, dec_pop_n, dec_push_n, dec_mem, dec_jump, dec_brk,
               ir_short, ir_ret, ir_keep, alu_take, stk_err
    );

    modport slave (
        input  mem_req, mem_we, ir_load, pc_inc, pc_load,
               stk_pop, stk_push, stk_sel, stk_keep, alu_en,
        output mem_ack, dec_pop_n, dec_push_n, dec_mem, dec_jump, dec_brk,
               ir_short, ir_ret, ir_keep, alu_take, stk_err
    );

endinterface

// File: rtl/uxn_xfer_counter.sv
// rtl/uxn_xfer_counter.sv - loadable down-counter for per-phase stack byte transfers
module uxn_xfer_counter
    import uxn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [XFER_W-1:0] load_val,
    input  logic              dec,
    output logic              zero,
    output logic              last
);

    logic [XFER_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - XFER_W'(1);
        end
    end

    assign zero = (cnt == '0);
    assign last = (cnt == XFER_W'(1));

endmodule

// File: rtl/uxn_mc_sequencer.sv
// rtl/uxn_mc_sequencer.sv - Uxn multicycle control FSM: fetch, decode, pop, exec, mem, push
module uxn_mc_sequencer
    import uxn_pkg::*;
#(
    parameter int TMO_W    = 8,
    parameter int MAX_XFER = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    uxn_mc_sequencer_if.master sif,
    output logic               busy,
    output logic               done,
    output logic               fault
);

    // Last count value before the (2**TMO_W-1)-th unacknowledged request cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    seq_state_t        state, state_nxt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              mem_two, mem_two_nxt;
    logic              mem_gap, mem_gap_nxt;
    logic              pop_load, pop_dec, pop_zero, pop_last;
    logic              push_load, push_dec, push_zero, push_last;
    logic [XFER_W-1:0] pop_bytes, push_bytes;
    logic              dec_bad;
    logic              tmo_hit;

    assign pop_bytes  = xfer_bytes(sif.dec_pop_n, sif.ir_short);
    assign push_bytes = xfer_bytes(sif.dec_push_n, sif.ir_short);
    assign dec_bad    = (int'(pop_bytes) > MAX_XFER) || (int'(push_bytes) > MAX_XFER)
                        || (sif.dec_mem == MEM_RSV);
    assign tmo_hit    = (tmo_cnt == TMO_LAST);

    uxn_xfer_counter u_pop_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pop_load),
        .load_val (pop_bytes),
        .dec      (pop_dec),
        .zero     (pop_zero),
        .last     (pop_last)
    );

    uxn_xfer_counter u_push_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (push_load),
        .load_val (push_bytes),
        .dec      (push_dec),
        .zero     (push_zero),
        .last     (push_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
            mem_two <= 1'b0;
            mem_gap <= 1'b0;
        end else begin
            state   <= state_nxt;
            mem_two <= mem_two_nxt;
            mem_gap <= mem_gap_nxt;
            // Any cycle without an outstanding request restarts the timeout window.
            if (sif.mem_req && !sif.mem_ack) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        mem_two_nxt  = mem_two;
        mem_gap_nxt  = 1'b0;
        pop_load     = 1'b0;
        pop_dec      = 1'b0;
        push_load    = 1'b0;
        push_dec     = 1'b0;
        sif.mem_req  = 1'b0;
        sif.mem_we   = 1'b0;
        sif.ir_load  = 1'b0;
        sif.pc_inc   = 1'b0;
        sif.pc_load  = 1'b0;
        sif.stk_pop  = 1'b0;
        sif.stk_push = 1'b0;
        sif.stk_sel  = 1'b0;
        sif.stk_keep = 1'b0;
        sif.alu_en   = 1'b0;
        done         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                sif.mem_req = 1'b1;
                if (sif.mem_ack) begin
                    sif.ir_load = 1'b1;
                    sif.pc_inc  = 1'b1;
                    state_nxt   = ST_DECODE;
                end else if (tmo_hit) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_DECODE: begin
                sif.stk_sel = sif.ir_ret;
                if (sif.dec_brk) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (dec_bad) begin
                    state_nxt = ST_FAULT;
                end else begin
                    pop_load    = 1'b1;
                    push_load   = 1'b1;
                    mem_two_nxt = sif.ir_short;
                    state_nxt   = (pop_bytes != '0) ? ST_POP : ST_EXEC;
                end
            end
            ST_POP: begin
                sif.stk_sel  = sif.ir_ret;
                sif.stk_keep = sif.ir_keep;
                sif.stk_pop  = !pop_zero;
                pop_dec      = !pop_zero;
                if (!pop_zero && sif.stk_err) begin
                    state_nxt = ST_FAULT;
                end else if (pop_zero || pop_last) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                sif.stk_sel = sif.ir_ret;
                sif.alu_en  = 1'b1;
                sif.pc_load = sif.dec_jump && sif.alu_take;
                if (sif.dec_mem != MEM_NONE) begin
                    state_nxt = ST_MEM;
                end else if (!push_zero) begin
                    state_nxt = ST_PUSH;
                end else begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_MEM: begin
                sif.stk_sel = sif.ir_ret;
                // A short access is two byte transactions with one idle cycle between them.
                if (!mem_gap) begin
                    sif.mem_req = 1'b1;
                    sif.mem_we  = (sif.dec_mem == MEM_ST);
                    if (sif.mem_ack) begin
                        if (mem_two) begin
                            mem_two_nxt = 1'b0;
                            mem_gap_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_PUSH;
                        end
                    end else if (tmo_hit) begin
                        state_nxt = ST_FAULT;
                    end
                end
            end
            ST_PUSH: begin
                // Entered with a zero count only after MEM; the idle cycle keeps FETCH off the ack.
                sif.stk_sel  = sif.ir_ret;
                sif.stk_push = !push_zero;
                push_dec     = !push_zero;
                if (!push_zero && sif.stk_err) begin
                    state_nxt = ST_FAULT;
                end else if (push_zero || push_last) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_FAULT;
            end
        endcase
    end

    assign busy  = (state != ST_IDLE) && (state != ST_FAULT);
    assign fault = (state == ST_FAULT);

endmodule

// File: tb/tb_uxn_mc_sequencer.sv
// tb/tb_uxn_mc_sequencer.sv - scoreboard bench for uxn_mc_sequencer with random programs
module tb_uxn_mc_sequencer;
    import uxn_pkg::*;

    localparam int MAXX = 4;
    localparam int EV_FETCH = 0, EV_POP = 1, EV_EXEC = 2, EV_MEM = 3, EV_PUSH = 4, EV_DONE = 5;

    typedef struct {
        bit       brk;
        logic [7:0] ir;
        int       pop_n;
        int       push_n;
        int       mem;
        bit       jump;
        bit       take;
        bit       err_pop;
    } instr_t;

    typedef struct {
        int kind;
        bit a;
        bit b;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, fault;

    uxn_mc_sequencer_if sif ();

    uxn_mc_sequencer #(.TMO_W(8), .MAX_XFER(MAXX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sif   (sif),
        .busy  (busy),
        .done  (done),
        .fault (fault)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     t0 = 0;
    ev_t    sbq[$];
    instr_t prog[$];
    int     fidx = 0;
    bit     pend_fetch = 0;
    bit     no_ack = 0;
    bit     rand_lat = 0;
    int     fixed_lat = 0;
    int     cur_lat = 0;
    int     wcnt = 0;
    bit     err_arm = 0;
    bit     exp_fault = 0;
    bit     prev_ack = 0;
    int     done_cnt = 0;
    int     done_rel = -1;
    int     req_cycles = 0;
    int     we_cycles = 0;
    int     pcl_cnt = 0;
    int     fetch_rel[$];

    assign sif.stk_err = err_arm && sif.stk_pop;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic ev_t mk_ev(input int kind, input bit a, input bit b);
        ev_t e;
        e.kind = kind;
        e.a = a;
        e.b = b;
        return e;
    endfunction

    task automatic see_ev(input int kind, input bit a, input bit b);
        ev_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL event: got kind=%0d a=%0b b=%0b required none (t=%0t)", kind, a, b, $time);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind || e.a != a || e.b != b) begin
                bad++;
                $display("FAIL event: got kind=%0d a=%0b b=%0b required kind=%0d a=%0b b=%0b (t=%0t)",
                         kind, a, b, e.kind, e.a, e.b, $time);
            end
        end
    endtask

    function automatic instr_t mk_instr(input bit brk, input logic [7:0] ir, input int pop_n,
                                        input int push_n, input int mem, input bit jump, input bit take);
        instr_t in;
        in.brk = brk;
        in.ir = ir;
        in.pop_n = pop_n;
        in.push_n = push_n;
        in.mem = mem;
        in.jump = jump;
        in.take = take;
        in.err_pop = 1'b0;
        return in;
    endfunction

    function automatic instr_t brk_instr();
        return mk_instr(1'b1, 8'h00, 0, 0, 0, 1'b0, 1'b0);
    endfunction

    function automatic instr_t rand_instr();
        instr_t in;
        int lim;
        in = mk_instr(1'b0, 8'($urandom_range(1, 255)), 0, 0, 0, 1'b0, 1'b0);
        lim = in.ir[IR_SHORT_BIT] ? MAXX / 2 : MAXX;
        in.pop_n = $urandom_range(0, lim);
        in.push_n = $urandom_range(0, lim);
        in.mem = $urandom_range(0, 2);
        in.jump = 1'($urandom_range(0, 1));
        in.take = 1'($urandom_range(0, 1));
        return in;
    endfunction

    // Expected strobe trace of a whole program; returns 1 if the program must end in fault.
    function automatic bit model_prog(input instr_t p[$]);
        int m;
        bit r;
        foreach (p[i]) begin
            m = p[i].ir[IR_SHORT_BIT] ? 2 : 1;
            r = p[i].ir[IR_RET_BIT];
            sbq.push_back(mk_ev(EV_FETCH, 1'b1, 1'b0));
            if (p[i].brk) begin
                sbq.push_back(mk_ev(EV_DONE, 1'b0, 1'b0));
                return 1'b0;
            end
            if (p[i].pop_n * m > MAXX || p[i].push_n * m > MAXX || p[i].mem == 3) return 1'b1;
            if (p[i].err_pop && p[i].pop_n > 0) begin
                sbq.push_back(mk_ev(EV_POP, r, p[i].ir[IR_KEEP_BIT]));
                return 1'b1;
            end
            repeat (p[i].pop_n * m) sbq.push_back(mk_ev(EV_POP, r, p[i].ir[IR_KEEP_BIT]));
            sbq.push_back(mk_ev(EV_EXEC, p[i].jump && p[i].take, 1'b0));
            if (p[i].mem != 0) repeat (m) sbq.push_back(mk_ev(EV_MEM, p[i].mem == 2, 1'b0));
            repeat (p[i].push_n * m) sbq.push_back(mk_ev(EV_PUSH, r, 1'b0));
        end
        sbq.push_back(mk_ev(EV_FETCH, 1'b1, 1'b0));
        sbq.push_back(mk_ev(EV_DONE, 1'b0, 1'b0));
        return 1'b0;
    endfunction

    task automatic drive_instr(input instr_t in);
        sif.dec_pop_n  = 3'(in.pop_n);
        sif.dec_push_n = 3'(in.push_n);
        sif.dec_mem    = mem_op_t'(in.mem[1:0]);
        sif.dec_jump   = in.jump;
        sif.dec_brk    = in.brk;
        sif.ir_short   = in.ir[IR_SHORT_BIT];
        sif.ir_ret     = in.ir[IR_RET_BIT];
        sif.ir_keep    = in.ir[IR_KEEP_BIT];
        sif.alu_take   = in.take;
        err_arm        = in.err_pop;
    endtask

    // Memory and decoder environment.
    initial begin
        sif.mem_ack = 1'b0;
        drive_instr(brk_instr());
        forever begin
            @(posedge clk);
            #1;
            if (pend_fetch) begin
                if (fidx < prog.size()) drive_instr(prog[fidx]);
                else drive_instr(brk_instr());
                fidx++;
                pend_fetch = 1'b0;
            end
            if (sif.mem_req && !sif.mem_ack && !no_ack) begin
                if (wcnt >= cur_lat) begin
                    sif.mem_ack = 1'b1;
                    wcnt = 0;
                    cur_lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
                end else begin
                    wcnt++;
                end
            end else begin
                sif.mem_ack = 1'b0;
            end
            @(negedge clk);
            if (sif.ir_load) pend_fetch = 1'b1;
        end
    end

    // Monitor: every strobe the DUT presents is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ack = 1'b0;
        end else begin
            if (prev_ack) check("req_gap", sif.mem_req, 0);
            prev_ack = sif.mem_req && sif.mem_ack;
            if (sif.mem_req) req_cycles++;
            if (sif.mem_req && sif.mem_we) we_cycles++;
            if (sif.pc_load) pcl_cnt++;
            if (sif.ir_load) begin
                fetch_rel.push_back(cyc - t0);
                see_ev(EV_FETCH, sif.pc_inc, sif.stk_sel);
            end else if (sif.mem_req && sif.mem_ack) begin
                see_ev(EV_MEM, sif.mem_we, 1'b0);
            end
            if (sif.stk_pop) see_ev(EV_POP, sif.stk_sel, sif.stk_keep);
            if (sif.stk_push) see_ev(EV_PUSH, sif.stk_sel, 1'b0);
            if (sif.alu_en) see_ev(EV_EXEC, sif.pc_load, 1'b0);
            if (done) begin
                done_cnt++;
                done_rel = cyc - t0;
                see_ev(EV_DONE, 1'b0, 1'b0);
            end
        end
    end

    function automatic logic [12:0] outs();
        return {sif.mem_req, sif.mem_we, sif.ir_load, sif.pc_inc, sif.pc_load, sif.stk_pop,
                sif.stk_push, sif.stk_sel, sif.stk_keep, sif.alu_en, busy, done, fault};
    endfunction

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run(input instr_t p[$], input bit stuck, input int bound);
        int  d0;
        bit  ended;
        prog = p;
        fidx = 0;
        exp_fault = stuck ? 1'b1 : model_prog(p);
        cur_lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
        wcnt = 0;
        req_cycles = 0;
        we_cycles = 0;
        pcl_cnt = 0;
        done_rel = -1;
        fetch_rel.delete();
        d0 = done_cnt;
        ended = 1'b0;
        pulse_start();
        for (int i = 0; i < bound && !ended; i++) begin
            @(posedge clk);
            #2;
            if (done_cnt != d0 || fault) ended = 1'b1;
        end
        check("run_end", ended, 1);
        check("run_fault", fault, exp_fault);
        check("sb_empty", sbq.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        pend_fetch = 1'b0;
        wcnt = 0;
        err_arm = 1'b0;
        no_ack = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_dead(input string name);
        pulse_start();
        repeat (4) @(posedge clk);
        #1;
        check(name, {busy, fault, sif.mem_req}, 3'b010);
    endtask

    initial begin
        instr_t p[$];
        instr_t in;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_outs", outs(), 0);

        // BRK with zero-wait memory
        p = {brk_instr()};
        run(p, 1'b0, 20);
        check("brk_fetch_cyc", fetch_rel.size() > 0 ? fetch_rel[0] : -1, 1);
        check("brk_done_cyc", done_rel, 2);
        check("brk_idle_cyc", cyc - t0, 3);
        check("brk_busy", busy, 0);

        // ADD byte: pop 2, exec, push 1, then the next fetch
        p = {mk_instr(1'b0, 8'h18, 2, 1, 0, 1'b0, 1'b0), brk_instr()};
        run(p, 1'b0, 40);
        check("add_refetch_cyc", fetch_rel.size() > 1 ? fetch_rel[1] : -1, 7);

        // ADD2 short: four pops, exec, two pushes on the work stack
        p = {mk_instr(1'b0, 8'h38, 2, 1, 0, 1'b0, 1'b0), brk_instr()};
        run(p, 1'b0, 40);

        // STA on the return stack with three wait cycles
        fixed_lat = 3;
        p = {mk_instr(1'b0, 8'h55, 3, 0, 2, 1'b0, 1'b0), brk_instr()};
        run(p, 1'b0, 60);
        check("sta_we_cycles", we_cycles, 4);
        fixed_lat = 0;

        // JCN not taken then taken
        p = {mk_instr(1'b0, 8'h0d, 2, 0, 0, 1'b1, 1'b0), mk_instr(1'b0, 8'h0d, 2, 0, 0, 1'b1, 1'b1),
             brk_instr()};
        run(p, 1'b0, 40);
        check("jcn_pc_load", pcl_cnt, 1);

        // Random programs with random memory latency
        rand_lat = 1'b1;
        for (int n = 0; n < 25; n++) begin
            p.delete();
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) p.push_back(rand_instr());
            p.push_back(brk_instr());
            run(p, 1'b0, 600);
        end
        rand_lat = 1'b0;

        // Reset in the middle of a fetch
        no_ack = 1'b1;
        prog = {brk_instr()};
        fidx = 0;
        pulse_start();
        @(posedge clk);
        #1;
        check("rst_mid_req", sif.mem_req, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", outs(), 0);
        @(negedge clk);
        #1;
        no_ack = 1'b0;
        wcnt = 0;
        pend_fetch = 1'b0;
        check("rst_hold_outs", outs(), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        p = {brk_instr()};
        run(p, 1'b0, 20);
        check("rst_refetch_cyc", fetch_rel.size() > 0 ? fetch_rel[0] : -1, 1);

        // Memory never acknowledges
        do_reset();
        no_ack = 1'b1;
        p = {mk_instr(1'b0, 8'h18, 2, 1, 0, 1'b0, 1'b0)};
        run(p, 1'b1, 400);
        check("tmo_req_cycles", req_cycles, 255);
        check("tmo_state", {busy, fault, sif.mem_req}, 3'b010);
        check_dead("tmo_start_ignored");

        // Stack error on the first pop
        do_reset();
        in = mk_instr(1'b0, 8'h58, 2, 1, 0, 1'b0, 1'b0);
        in.err_pop = 1'b1;
        p = {in};
        run(p, 1'b0, 40);
        check_dead("stkerr_start_ignored");

        // Decoder counts above the limit and the reserved memory op
        do_reset();
        p = {mk_instr(1'b0, 8'h20, 3, 1, 0, 1'b0, 1'b0)};
        run(p, 1'b0, 40);
        do_reset();
        p = {mk_instr(1'b0, 8'h20, 1, 3, 0, 1'b0, 1'b0)};
        run(p, 1'b0, 40);
        do_reset();
        p = {mk_instr(1'b0, 8'h14, 1, 1, 3, 1'b0, 1'b0)};
        run(p, 1'b0, 40);
        check_dead("decfault_start_ignored");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
